// File: rtl/rv32_pkg.sv
// Shared constants for the decode-stage branch interface.
package rv32_pkg;

  // Two-bit branch outcome codes from the ID control unit.
  localparam logic [1:0] OUTCOME_CORRECT = 2'b11;
  localparam logic [1:0] OUTCOME_MISPRED = 2'b00;
  localparam logic [1:0] OUTCOME_NONBR   = 2'b10;
  localparam logic [1:0] OUTCOME_RSVD    = 2'b01;

  // Instructions are word aligned, so the table index starts above the byte offset.
  localparam int unsigned IDX_LSB = 2;

endpackage

// File: rtl/sat_counter.sv
// Up/down saturating counter with a configurable reset value.
module sat_counter #(
  parameter int unsigned          CTR_BITS  = 2,
  parameter logic [CTR_BITS-1:0]  RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CTR_BITS-1:0] count_next_o
);

  localparam logic [CTR_BITS-1:0] CtrMax = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0] count_q, count_d;

  // Saturating step; the next-state value is exported so a same-cycle lookup sees it.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != CtrMax)) begin
      count_d = count_q + CTR_BITS'(1);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CTR_BITS'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next_o = count_d;

endmodule

// File: rtl/branch_predict_table.sv
// Table of saturating counters indexed by PC, looked up in IF and trained in ID,
// with saturating branch / mispredict statistics.
module branch_predict_table
  import rv32_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_en,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_prediction,
  input  logic [1:0]            branch_outcome,
  input  logic                  stats_clear,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned         ENTRIES  = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CtrReset = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

  if (INDEX_BITS + IDX_LSB > PC_WIDTH) begin : gen_bad_index_width
    $error("branch_predict_table: INDEX_BITS+2 exceeds PC_WIDTH");
  end
  if (CTR_BITS < 1) begin : gen_bad_ctr_bits
    $error("branch_predict_table: CTR_BITS must be at least 1");
  end

  logic [INDEX_BITS-1:0] lookup_idx;
  logic                  mispred;
  logic                  train;
  logic                  actual_taken;
  logic                  unused_lookup_pc;

  assign lookup_idx       = lookup_pc[IDX_LSB +: INDEX_BITS];
  // Upper and byte-offset PC bits do not take part in indexing.
  assign unused_lookup_pc = ^lookup_pc;

  assign mispred      = (branch_outcome == OUTCOME_MISPRED);
  assign train        = upd_en && ((branch_outcome == OUTCOME_CORRECT) || mispred);
  // A mispredict means the branch went the other way from what it carried.
  assign actual_taken = upd_prediction ^ mispred;

  logic [CTR_BITS-1:0] ctr_next [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : gen_entry
    logic hit;
    assign hit = train && (upd_index == INDEX_BITS'(i));

    sat_counter #(
      .CTR_BITS  (CTR_BITS),
      .RESET_VAL (CtrReset)
    ) u_ctr (
      .clk          (clk),
      .rst_n        (rst_n),
      .inc_i        (hit && actual_taken),
      .dec_i        (hit && !actual_taken),
      .count_next_o (ctr_next[i])
    );
  end

  logic                  prediction_q, prediction_d;
  logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;

  // Lookup reads the post-update counter so a same-index train is bypassed.
  always_comb begin
    prediction_d = prediction_q;
    pred_index_d = pred_index_q;
    if (lookup_en) begin
      pred_index_d = lookup_idx;
      prediction_d = ctr_next[lookup_idx][CTR_BITS-1];
    end
  end

  logic [STAT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  // Saturating statistics; clear wins over a same-cycle event.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (stats_clear) begin
      branch_count_d     = '0;
      mispredict_count_d = '0;
    end else if (train) begin
      if (branch_count_q != '1) begin
        branch_count_d = branch_count_q + STAT_WIDTH'(1);
      end
      if (mispred && (mispredict_count_q != '1)) begin
        mispredict_count_d = mispredict_count_q + STAT_WIDTH'(1);
      end
    end
  end

  // Prediction and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prediction_q       <= 1'b0;
      pred_index_q       <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      prediction_q       <= prediction_d;
      pred_index_q       <= pred_index_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign prediction       = prediction_q;
  assign pred_index       = pred_index_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_table.sv
// Randomised self-checking bench: default-parameter DUT plus a 4-bit-statistics DUT
// sharing the same stimulus, both compared against a table-of-integers model.
module tb_branch_predict_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        upd_en;
  logic [5:0]  upd_index;
  logic        upd_prediction;
  logic [1:0]  branch_outcome;
  logic        stats_clear;

  logic        pred_a, pred_b;
  logic [5:0]  pidx_a, pidx_b;
  logic [15:0] bc_a, mc_a;
  logic [3:0]  bc_b, mc_b;

  always #5 clk = ~clk;

  branch_predict_table u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_en        (lookup_en),
    .lookup_pc        (lookup_pc),
    .prediction       (pred_a),
    .pred_index       (pidx_a),
    .upd_en           (upd_en),
    .upd_index        (upd_index),
    .upd_prediction   (upd_prediction),
    .branch_outcome   (branch_outcome),
    .stats_clear      (stats_clear),
    .branch_count     (bc_a),
    .mispredict_count (mc_a)
  );

  branch_predict_table #(
    .STAT_WIDTH (4)
  ) u_dut_s4 (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_en        (lookup_en),
    .lookup_pc        (lookup_pc),
    .prediction       (pred_b),
    .pred_index       (pidx_b),
    .upd_en           (upd_en),
    .upd_index        (upd_index),
    .upd_prediction   (upd_prediction),
    .branch_outcome   (branch_outcome),
    .stats_clear      (stats_clear),
    .branch_count     (bc_b),
    .mispredict_count (mc_b)
  );

  // Reference model: plain integer counters, 2-bit range 0..3.
  int m_ctr [64];
  int m_pred, m_pidx;
  int m_bc16, m_mc16, m_bc4, m_mc4;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_pred = 0; m_pidx = 0;
    m_bc16 = 0; m_mc16 = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  // One clock edge of behaviour, from the current input values.
  task automatic model_step();
    bit is_br, is_mis, taken;
    is_mis = (branch_outcome == 2'b00);
    is_br  = upd_en && (branch_outcome == 2'b11 || is_mis);
    if (is_br) begin
      taken = upd_prediction ^ is_mis;
      if (taken) m_ctr[upd_index] = (m_ctr[upd_index] < 3) ? m_ctr[upd_index] + 1 : 3;
      else       m_ctr[upd_index] = (m_ctr[upd_index] > 0) ? m_ctr[upd_index] - 1 : 0;
    end
    if (lookup_en) begin
      m_pidx = int'(lookup_pc / 4) % 64;
      m_pred = (m_ctr[m_pidx] >= 2) ? 1 : 0;
    end
    if (stats_clear) begin
      m_bc16 = 0; m_mc16 = 0; m_bc4 = 0; m_mc4 = 0;
    end else if (is_br) begin
      if (m_bc16 < 65535) m_bc16++;
      if (m_bc4 < 15) m_bc4++;
      if (is_mis && m_mc16 < 65535) m_mc16++;
      if (is_mis && m_mc4 < 15) m_mc4++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_pred"},   pred_a, m_pred);
    check({tag, "_pred4"},  pred_b, m_pred);
    check({tag, "_pidx"},   pidx_a, m_pidx);
    check({tag, "_pidx4"},  pidx_b, m_pidx);
    check({tag, "_bc"},     bc_a,   m_bc16);
    check({tag, "_mc"},     mc_a,   m_mc16);
    check({tag, "_bc4"},    bc_b,   m_bc4);
    check({tag, "_mc4"},    mc_b,   m_mc4);
  endtask

  task automatic drive(input bit le, input int unsigned pc, input bit ue, input int ui,
                       input bit up, input bit [1:0] oc, input bit sc);
    lookup_en      = le;
    lookup_pc      = pc;
    upd_en         = ue;
    upd_index      = 6'(ui);
    upd_prediction = up;
    branch_outcome = oc;
    stats_clear    = sc;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic scan_table(input string tag);
    for (int i = 0; i < 64; i++) begin
      drive(1, i * 4, 0, 0, 0, 2'b10, 0);
      step(tag);
    end
  endtask

  initial begin
    int saved_bc, saved_mc, saved_pred, saved_pidx;
    drive(0, 0, 0, 0, 0, 2'b10, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Every index starts weakly not-taken.
    scan_table("scan0");

    // Two actually-taken updates to index 5, then look it up.
    drive(0, 0, 1, 5, 0, 2'b00, 0); step("t2_upd");
    step("t2_upd");
    drive(1, 32'h14, 0, 0, 0, 2'b10, 0); step("t2_look");
    check("t2_pred_const", pred_a, 1);
    check("t2_bc_const", bc_a, 2);
    check("t2_mc_const", mc_a, 2);

    // Same-cycle lookup and update of index 5: bypassed result.
    drive(1, 32'h14, 1, 5, 1, 2'b00, 0); step("t3_a");
    check("t3_pred_a", pred_a, 1);
    step("t3_b");
    check("t3_pred_b", pred_a, 0);

    // Saturation at index 0.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 0, 1, 2'b11, 0); step("t4_sat");
    end
    drive(1, 0, 1, 0, 1, 2'b00, 0); step("t4_dec");
    check("t4_pred_const", pred_a, 1);

    // Non-branch and reserved outcomes leave table and stats alone.
    saved_bc = m_bc16; saved_mc = m_mc16;
    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 1), $urandom, 1, $urandom_range(0, 63), $urandom_range(0, 1),
            ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 0);
      step("t5_nonbr");
    end
    check("t5_bc_hold", bc_a, saved_bc);
    check("t5_mc_hold", mc_a, saved_mc);
    scan_table("t5_scan");

    // Stall: outputs hold whatever training happens.
    drive(1, 32'h14, 0, 0, 0, 2'b10, 0); step("t5_pre");
    saved_pred = m_pred; saved_pidx = m_pidx;
    for (int i = 0; i < 5; i++) begin
      drive(0, $urandom, 1, 5, 1, 2'b11, 0); step("t5_stall");
      check("t5_pred_hold", pred_a, saved_pred);
      check("t5_pidx_hold", pidx_a, saved_pidx);
    end

    // Randomised mix with index collisions and rare clears.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? $urandom : ($urandom_range(0, 7) * 4),
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 63) : $urandom_range(0, 7),
            $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 63) == 0);
      step("rand");
    end

    // Statistics saturation on the 4-bit instance, then clear priority.
    drive(0, 0, 0, 0, 0, 2'b10, 1); step("t6_clr");
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, $urandom_range(0, 63), $urandom_range(0, 1), 2'b00, 0);
      step("t6_mis");
    end
    check("t6_bc4_sat", bc_b, 15);
    check("t6_mc4_sat", mc_b, 15);
    check("t6_bc_20", bc_a, 20);
    drive(0, 0, 1, 3, 0, 2'b00, 1); step("t6_clrpri");
    check("t6_bc4_clr", bc_b, 0);
    check("t6_mc_clr", mc_a, 0);

    // Train index 9 strongly taken, then reset in the middle of a training cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h24, 1, 9, 1, 2'b11, 0); step("t6_train");
    end
    check("t6_pre_rst_pred", pred_a, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("t6_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    scan_table("t6_scan");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
